regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised successor to the 32x32 processor register file: configurable data width and depth.
- Two combinational read ports and one synchronous write port.
- Optional write-to-read bypass.
- Per-register pending scoreboard, so the pipeline can stall on registers awaiting multicycle (mult/div) results.
- Sits between decode and writeback in the proc datapath and drives operand and hazard signals to the stall logic.

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero: writes are ignored and it is never pending.
- BYPASS, 1, when 1 a same-cycle write to the register being read is forwarded to the read port.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- ctrl_reset  input  1  synchronous, active-high reset.
- ctrl_writeEnable  input  1  write strobe.
- ctrl_writeReg  input  ADDR_WIDTH  write index.
- data_writeReg  input  DATA_WIDTH  write data.
- ctrl_readRegA  input  ADDR_WIDTH  read port A index.
- ctrl_readRegB  input  ADDR_WIDTH  read port B index.
- data_readRegA  output  DATA_WIDTH  port A data, combinational.
- data_readRegB  output  DATA_WIDTH  port B data, combinational.
- ctrl_setPending  input  1  mark ctrl_pendingReg as awaiting a result.
- ctrl_pendingReg  input  ADDR_WIDTH  register to mark pending.
- pending_readRegA  output  1  register at ctrl_readRegA is pending.
- pending_readRegB  output  1  register at ctrl_readRegB is pending.
- pending_any  output  1  OR of all pending bits.

Behaviour:
- Clocking and reset:
  - One clock, clock; reset is synchronous and active-high on ctrl_reset.
  - On a rising edge with ctrl_reset=1: all registers are cleared to 0 and all pending bits to 0.
  - Reset has priority over any write or set in the same cycle.
  - After reset, both read ports return 0 and all pending outputs are 0.
  - Reset asserted mid-operation discards the in-flight write and all pending marks.
- Write:
  - On a rising edge with ctrl_writeEnable=1, data_writeReg is stored at ctrl_writeReg.
  - Write latency: the stored value is visible through array reads on the cycle after the edge.
  - If ZERO_REG=1 and ctrl_writeReg=0, the write is dropped.
- Read:
  - Purely combinational from the array; no latency.
  - When ZERO_REG=1 and index=0, the port returns 0.
  - When BYPASS=1, ctrl_writeEnable=1, ctrl_writeReg equals the read index, and the write is not dropped, the port returns data_writeReg in the same cycle.
  - When BYPASS=0, the port returns the old value until the edge.
  - Both ports may read the same index; each behaves independently.
- Pending scoreboard (one bit per register):
  - Set: rising edge with ctrl_setPending=1 sets pending[ctrl_pendingReg].
  - Clear: rising edge with a non-dropped write clears pending[ctrl_writeReg].
  - Same register set and written in one cycle: set wins, and the bit ends at 1 (a new producer was issued).
  - Different registers set and written in one cycle: both updates apply.
  - ZERO_REG=1: a set on register 0 is ignored.
  - Setting an already-pending register leaves it at 1, with no error.
  - pending_readRegA/B reflect registered bits only; there is no bypass of a same-cycle clear.
  - pending_any is combinational OR of all bits.
- Width rules:
  - Indices are unsigned and cover the full depth; no out-of-range index exists.
  - Data is stored as-is, with no sign handling.

Test Plan:
1. ctrl_reset=1 for one cycle after random writes -> next cycle every read index returns 0; pending_any=0.
2. Write 32'hDEADBEEF to r5, then read A=5, B=5 next cycle -> both 32'hDEADBEEF. Same-cycle read with BYPASS=1 -> 32'hDEADBEEF. Same-cycle read with BYPASS=0 -> prior value 0.
3. ZERO_REG=1: write 32'hFFFFFFFF to r0 with ctrl_setPending on r0 -> read r0 returns 0; pending_readRegA=0 for index 0.
4. Set pending r7, then after 3 cycles write 32'h12 to r7 -> pending_readRegA=1 on cycles 1-3, 0 after the write edge; read returns 32'h12.
5. Same cycle: ctrl_setPending on r9 plus write r9=32'h1 -> pending r9=1 afterward; data r9=32'h1. Separately, set r3 with write r4 -> r3 pending, r4 not pending.
6. Parameter sweep DATA_WIDTH=16, ADDR_WIDTH=3: write index 7 = 16'hA5A5, then reset asserted in the same cycle as a write to r2 -> r7=0, r2=0, no pending bits set.

Source files
------------

// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
//   Parametrised processor register file with two combinational read ports,
//   one synchronous write port, optional write-to-read bypass and a
//   per-register pending scoreboard.
//
//   The scoreboard lets the stall logic hold off consumers of registers that
//   are still waiting for a multicycle (mult/div) result.
//
// Parameters
//   DATA_WIDTH : bits per register
//   ADDR_WIDTH : register index width; depth = 2**ADDR_WIDTH
//   ZERO_REG   : 1 -> register 0 always reads 0, is never written and is
//                never pending
//   BYPASS     : 1 -> a same-cycle write to the register being read is
//                forwarded to the read port
//
// Ports
//   clock              in   rising-edge clock for all state
//   ctrl_reset         in   synchronous active-high reset
//   ctrl_writeEnable   in   write strobe
//   ctrl_writeReg      in   write index
//   data_writeReg      in   write data
//   ctrl_readRegA/B    in   read indices
//   data_readRegA/B    out  read data (combinational)
//   ctrl_setPending    in   mark ctrl_pendingReg as awaiting a result
//   ctrl_pendingReg    in   register to mark pending
//   pending_readRegA/B out  pending bit of the register at each read index
//   pending_any        out  OR of all pending bits
// ---------------------------------------------------------------------------
module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  input  logic                  ctrl_setPending,
  input  logic [ADDR_WIDTH-1:0] ctrl_pendingReg,
  output logic                  pending_readRegA,
  output logic                  pending_readRegB,
  output logic                  pending_any
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      pending_q;
  logic [DEPTH-1:0]      pending_d;

  logic write_ok_s;
  logic set_ok_s;

  // Qualify write and set strobes: register 0 swallows both when hardwired.
  always_comb begin
    write_ok_s = ctrl_writeEnable;
    set_ok_s   = ctrl_setPending;
    if ((ZERO_REG != 0) && (ctrl_writeReg == IDX_ZERO)) begin
      write_ok_s = 1'b0;
    end else begin
      write_ok_s = ctrl_writeEnable;
    end
    if ((ZERO_REG != 0) && (ctrl_pendingReg == IDX_ZERO)) begin
      set_ok_s = 1'b0;
    end else begin
      set_ok_s = ctrl_setPending;
    end
  end

  // Scoreboard next state. The set is applied after the clear so that a new
  // producer issued in the same cycle as a writeback to that register wins.
  always_comb begin
    pending_d = pending_q;
    if (write_ok_s) begin
      pending_d[ctrl_writeReg] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (set_ok_s) begin
      pending_d[ctrl_pendingReg] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
  end

  // Register array and scoreboard state; reset overrides write and set.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= DATA_ZERO;
      end
      pending_q <= {DEPTH{1'b0}};
    end else begin
      if (write_ok_s) begin
        regs_q[ctrl_writeReg] <= data_writeReg;
      end
      pending_q <= pending_d;
    end
  end

  // Read port A: zero register, then bypass, then array.
  always_comb begin
    data_readRegA = regs_q[ctrl_readRegA];
    if ((ZERO_REG != 0) && (ctrl_readRegA == IDX_ZERO)) begin
      data_readRegA = DATA_ZERO;
    end else if ((BYPASS != 0) && write_ok_s && (ctrl_writeReg == ctrl_readRegA)) begin
      data_readRegA = data_writeReg;
    end else begin
      data_readRegA = regs_q[ctrl_readRegA];
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    data_readRegB = regs_q[ctrl_readRegB];
    if ((ZERO_REG != 0) && (ctrl_readRegB == IDX_ZERO)) begin
      data_readRegB = DATA_ZERO;
    end else if ((BYPASS != 0) && write_ok_s && (ctrl_writeReg == ctrl_readRegB)) begin
      data_readRegB = data_writeReg;
    end else begin
      data_readRegB = regs_q[ctrl_readRegB];
    end
  end

  // Pending outputs come from registered bits only; a same-cycle clear is
  // not forwarded, so a consumer stalls one extra cycle behind a writeback.
  assign pending_readRegA = pending_q[ctrl_readRegA];
  assign pending_readRegB = pending_q[ctrl_readRegB];
  assign pending_any      = |pending_q;

endmodule

// File: tb/tb_regfile_param.sv
// ---------------------------------------------------------------------------
// tb_regfile_param
//   Directed bench for regfile_param. Three instances:
//     u_byp   : default parameters (32x32, ZERO_REG=1, BYPASS=1)
//     u_nobyp : same, BYPASS=0, driven by the same inputs as u_byp
//     u_small : DATA_WIDTH=16, ADDR_WIDTH=3
// ---------------------------------------------------------------------------
module tb_regfile_param;

  logic        clock;
  logic        rst;
  logic        we;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic        setp;
  logic [4:0]  preg;

  logic [31:0] rda_y, rdb_y, rda_n, rdb_n;
  logic        pa_y, pb_y, pany_y, pa_n, pb_n, pany_n;

  logic        rst_c, we_c, setp_c;
  logic [2:0]  wreg_c, ra_c, rb_c, preg_c;
  logic [15:0] wdata_c, rda_c, rdb_c;
  logic        pa_c, pb_c, pany_c;

  int checks;
  int errors;

  regfile_param u_byp (
    .clock(clock), .ctrl_reset(rst), .ctrl_writeEnable(we),
    .ctrl_writeReg(wreg), .data_writeReg(wdata),
    .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(rda_y), .data_readRegB(rdb_y),
    .ctrl_setPending(setp), .ctrl_pendingReg(preg),
    .pending_readRegA(pa_y), .pending_readRegB(pb_y), .pending_any(pany_y)
  );

  regfile_param #(.BYPASS(0)) u_nobyp (
    .clock(clock), .ctrl_reset(rst), .ctrl_writeEnable(we),
    .ctrl_writeReg(wreg), .data_writeReg(wdata),
    .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(rda_n), .data_readRegB(rdb_n),
    .ctrl_setPending(setp), .ctrl_pendingReg(preg),
    .pending_readRegA(pa_n), .pending_readRegB(pb_n), .pending_any(pany_n)
  );

  regfile_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) u_small (
    .clock(clock), .ctrl_reset(rst_c), .ctrl_writeEnable(we_c),
    .ctrl_writeReg(wreg_c), .data_writeReg(wdata_c),
    .ctrl_readRegA(ra_c), .ctrl_readRegB(rb_c),
    .data_readRegA(rda_c), .data_readRegB(rdb_c),
    .ctrl_setPending(setp_c), .ctrl_pendingReg(preg_c),
    .pending_readRegA(pa_c), .pending_readRegB(pb_c), .pending_any(pany_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_write(input logic [4:0] r, input logic [31:0] d);
    we = 1'b1; wreg = r; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic test_reset();
    drive_write(5'd1, 32'h0000_0011);
    drive_write(5'd2, 32'h0000_0022);
    drive_write(5'd31, 32'hCAFE_F00D);
    setp = 1'b1; preg = 5'd6;
    step();
    setp = 1'b0;
    ra = 5'd31; rb = 5'd6; #1;
    checks++;
    if (rda_y !== 32'hCAFE_F00D || pb_y !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: r31=%h pend6=%b required r31=cafef00d pend6=1", rda_y, pb_y);
    end
    // Reset together with a write and a set: reset must win.
    rst = 1'b1; we = 1'b1; wreg = 5'd8; wdata = 32'h8888_8888; setp = 1'b1; preg = 5'd9;
    step();
    rst = 1'b0; we = 1'b0; setp = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra = i[4:0]; rb = 5'(31 - i); #1;
      checks++;
      if (rda_y !== 32'h0 || rdb_y !== 32'h0 || rda_n !== 32'h0 || pa_y !== 1'b0 || pb_y !== 1'b0) begin
        errors++;
        $display("FAIL reset_read[%0d]: a=%h b=%h nb=%h pa=%b pb=%b required all 0", i, rda_y, rdb_y, rda_n, pa_y, pb_y);
      end
    end
    checks++;
    if (pany_y !== 1'b0 || pany_n !== 1'b0) begin
      errors++;
      $display("FAIL reset_pending_any: %b/%b required 0", pany_y, pany_n);
    end
  endtask

  task automatic test_write_bypass();
    ra = 5'd5; rb = 5'd5;
    we = 1'b1; wreg = 5'd5; wdata = 32'hDEAD_BEEF; #1;
    checks++;
    if (rda_y !== 32'hDEAD_BEEF || rdb_y !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_same_cycle: a=%h b=%h required deadbeef", rda_y, rdb_y);
    end
    checks++;
    if (rda_n !== 32'h0 || rdb_n !== 32'h0) begin
      errors++;
      $display("FAIL nobypass_same_cycle: a=%h b=%h required 0", rda_n, rdb_n);
    end
    step();
    we = 1'b0; #1;
    checks++;
    if (rda_y !== 32'hDEAD_BEEF || rdb_y !== 32'hDEAD_BEEF || rda_n !== 32'hDEAD_BEEF || rdb_n !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_next_cycle: %h %h %h %h required deadbeef", rda_y, rdb_y, rda_n, rdb_n);
    end
  endtask

  task automatic test_zero_reg();
    ra = 5'd0; rb = 5'd0;
    we = 1'b1; wreg = 5'd0; wdata = 32'hFFFF_FFFF; setp = 1'b1; preg = 5'd0; #1;
    checks++;
    if (rda_y !== 32'h0) begin
      errors++;
      $display("FAIL zero_bypass: a=%h required 0", rda_y);
    end
    step();
    we = 1'b0; setp = 1'b0; #1;
    checks++;
    if (rda_y !== 32'h0 || rdb_n !== 32'h0 || pa_y !== 1'b0 || pany_y !== 1'b0) begin
      errors++;
      $display("FAIL zero_reg: a=%h nb=%h pa=%b pany=%b required 0/0/0/0", rda_y, rdb_n, pa_y, pany_y);
    end
  endtask

  task automatic test_pending_clear();
    ra = 5'd7; rb = 5'd7;
    setp = 1'b1; preg = 5'd7;
    step();
    setp = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++;
      if (pa_y !== 1'b1 || pany_y !== 1'b1) begin
        errors++;
        $display("FAIL pending_cycle%0d: pa=%b pany=%b required 1/1", c, pa_y, pany_y);
      end
      if (c < 3) step();
    end
    // Writeback drives this cycle; pending must not be bypassed.
    we = 1'b1; wreg = 5'd7; wdata = 32'h0000_0012; #1;
    checks++;
    if (pa_y !== 1'b1 || rda_y !== 32'h0000_0012 || rdb_n !== 32'h0) begin
      errors++;
      $display("FAIL pending_during_write: pa=%b a=%h nb=%h required 1/00000012/0", pa_y, rda_y, rdb_n);
    end
    step();
    we = 1'b0; #1;
    checks++;
    if (pa_y !== 1'b0 || pany_y !== 1'b0 || rda_y !== 32'h0000_0012) begin
      errors++;
      $display("FAIL pending_cleared: pa=%b pany=%b a=%h required 0/0/00000012", pa_y, pany_y, rda_y);
    end
  endtask

  task automatic test_set_and_write();
    setp = 1'b1; preg = 5'd9; we = 1'b1; wreg = 5'd9; wdata = 32'h0000_0001;
    step();
    setp = 1'b0; we = 1'b0; ra = 5'd9; #1;
    checks++;
    if (pa_y !== 1'b1 || rda_y !== 32'h0000_0001) begin
      errors++;
      $display("FAIL set_wins: pa=%b a=%h required 1/00000001", pa_y, rda_y);
    end
    setp = 1'b1; preg = 5'd3; we = 1'b1; wreg = 5'd4; wdata = 32'h0000_0044;
    step();
    setp = 1'b0; we = 1'b0; ra = 5'd3; rb = 5'd4; #1;
    checks++;
    if (pa_y !== 1'b1 || pb_y !== 1'b0 || rdb_y !== 32'h0000_0044) begin
      errors++;
      $display("FAIL set_write_diff: pa=%b pb=%b b=%h required 1/0/00000044", pa_y, pb_y, rdb_y);
    end
    // Re-setting an already-pending register keeps it set.
    setp = 1'b1; preg = 5'd3;
    step();
    setp = 1'b0; #1;
    checks++;
    if (pa_y !== 1'b1) begin
      errors++;
      $display("FAIL reset_pending_twice: pa=%b required 1", pa_y);
    end
    drive_write(5'd3, 32'h0000_0033);
    drive_write(5'd9, 32'h0000_0099);
    #1;
    checks++;
    if (pany_y !== 1'b0 || rda_y !== 32'h0000_0033) begin
      errors++;
      $display("FAIL all_cleared: pany=%b a=%h required 0/00000033", pany_y, rda_y);
    end
  endtask

  task automatic test_back_to_back();
    drive_write(5'd10, 32'hA0A0_0010);
    drive_write(5'd11, 32'hB0B0_0011);
    ra = 5'd10; rb = 5'd11; #1;
    checks++;
    if (rda_y !== 32'hA0A0_0010 || rdb_y !== 32'hB0B0_0011) begin
      errors++;
      $display("FAIL back_to_back: a=%h b=%h required a0a00010/b0b00011", rda_y, rdb_y);
    end
    // Overwrite r10 while both ports read it: bypass shows new, array shows old.
    ra = 5'd10; rb = 5'd10;
    we = 1'b1; wreg = 5'd10; wdata = 32'h1234_5678; #1;
    checks++;
    if (rda_y !== 32'h1234_5678 || rdb_n !== 32'hA0A0_0010) begin
      errors++;
      $display("FAIL overwrite_bypass: a=%h nb=%h required 12345678/a0a00010", rda_y, rdb_n);
    end
    step();
    we = 1'b0;
  endtask

  task automatic test_param_sweep();
    rst_c = 1'b1;
    step();
    rst_c = 1'b0;
    we_c = 1'b1; wreg_c = 3'd7; wdata_c = 16'hA5A5;
    step();
    we_c = 1'b0; setp_c = 1'b1; preg_c = 3'd5;
    step();
    setp_c = 1'b0; ra_c = 3'd7; rb_c = 3'd5; #1;
    checks++;
    if (rda_c !== 16'hA5A5 || pb_c !== 1'b1 || pany_c !== 1'b1) begin
      errors++;
      $display("FAIL small_write: r7=%h pb=%b pany=%b required a5a5/1/1", rda_c, pb_c, pany_c);
    end
    rst_c = 1'b1; we_c = 1'b1; wreg_c = 3'd2; wdata_c = 16'h1234; setp_c = 1'b1; preg_c = 3'd1;
    step();
    rst_c = 1'b0; we_c = 1'b0; setp_c = 1'b0; ra_c = 3'd7; rb_c = 3'd2; #1;
    checks++;
    if (rda_c !== 16'h0 || rdb_c !== 16'h0 || pany_c !== 1'b0) begin
      errors++;
      $display("FAIL small_reset: r7=%h r2=%h pany=%b required 0/0/0", rda_c, rdb_c, pany_c);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; we = 1'b0; wreg = 5'd0; wdata = 32'h0; ra = 5'd0; rb = 5'd0;
    setp = 1'b0; preg = 5'd0;
    rst_c = 1'b1; we_c = 1'b0; setp_c = 1'b0; wreg_c = 3'd0; ra_c = 3'd0; rb_c = 3'd0;
    preg_c = 3'd0; wdata_c = 16'h0;
    step();
    step();
    rst = 1'b0; rst_c = 1'b0;
    test_reset();
    test_write_bypass();
    test_zero_reg();
    test_pending_clear();
    test_set_and_write();
    test_back_to_back();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
